// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
// UART receiver front end: synchronizes the asynchronous rx line, runs an
// internal OVERSAMPLE x baud tick generator and recovers 8N1 frames
// (8E1 when UART_RX_PARITY_EN is defined).
//
// Optional feature macro: UART_RX_PARITY_EN
//   Adds a PARITY state between DATA and STOP (even parity) and the
//   parity_err output port.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   rx         in   serial line, idle high, asynchronous to clk
//   rx_data    out  [7:0] last correctly framed byte, LSB received first
//   rx_done    out  one-clk pulse, rx_data updated this cycle
//   frame_err  out  one-clk pulse, stop bit sampled low, byte discarded
//   parity_err out  one-clk pulse, parity mismatch (UART_RX_PARITY_EN only)
//   rx_busy    out  high whenever the receiver is not idle
module uart_rx_deserializer #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       rx_busy
);

  localparam int unsigned TICK_RATE = BAUD * OVERSAMPLE;
  localparam int unsigned DIV       = (CLK_HZ + TICK_RATE / 2) / TICK_RATE;
  localparam int unsigned DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SAMP_W    = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [SAMP_W-1:0] HALF_LAST = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] FULL_LAST = SAMP_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state;
  logic              rx_meta;
  logic              rx_sync;
  logic              rx_prev;
  logic [DIV_W-1:0]  tick_cnt;
  logic [SAMP_W-1:0] samp_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_reg;
  logic              tick_c;
  logic              start_c;
`ifdef UART_RX_PARITY_EN
  logic              parity_bit;
`endif

  // Two-flop synchronizer plus one history flop for falling-edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign start_c = (state == IDLE) && rx_prev && !rx_sync;
  assign tick_c  = (tick_cnt == DIV_LAST);

  // Oversample tick divider; restarted on the start edge so every
  // sample point is phase-locked to the detected falling edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (start_c || tick_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + DIV_W'(1);
    end
  end

  // Frame recovery FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      samp_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start_c) begin
            state    <= START;
            samp_cnt <= '0;
            rx_busy  <= 1'b1;
          end
        end

        // Mid-start-bit check rejects glitches shorter than half a bit
        START: begin
          if (tick_c) begin
            if (samp_cnt == HALF_LAST) begin
              samp_cnt <= '0;
              bit_cnt  <= '0;
              if (!rx_sync) begin
                state <= DATA;
              end else begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              samp_cnt <= samp_cnt + SAMP_W'(1);
            end
          end
        end

        // LSB arrives first, so shift right with the new bit at the MSB
        DATA: begin
          if (tick_c) begin
            if (samp_cnt == FULL_LAST) begin
              samp_cnt  <= '0;
              shift_reg <= {rx_sync, shift_reg[7:1]};
              if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else begin
              samp_cnt <= samp_cnt + SAMP_W'(1);
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_c) begin
            if (samp_cnt == FULL_LAST) begin
              samp_cnt   <= '0;
              parity_bit <= rx_sync;
              state      <= STOP;
            end else begin
              samp_cnt <= samp_cnt + SAMP_W'(1);
            end
          end
        end
`endif

        // Framing error wins over parity error; either one discards the byte
        STOP: begin
          if (tick_c) begin
            if (samp_cnt == FULL_LAST) begin
              samp_cnt <= '0;
              state    <= IDLE;
              rx_busy  <= 1'b0;
              if (!rx_sync) begin
                frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if (^{shift_reg, parity_bit}) begin
                parity_err <= 1'b1;
`endif
              end else begin
                rx_data <= shift_reg;
                rx_done <= 1'b1;
              end
            end else begin
              samp_cnt <= samp_cnt + SAMP_W'(1);
            end
          end
        end

        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
module tb_uart_rx_deserializer;

  localparam int unsigned CLK_HZ  = 1_600_000;
  localparam int unsigned BAUD    = 10_000;
  localparam int          BIT_CLK = 160;
`ifdef UART_RX_PARITY_EN
  localparam int          FRAME_BITS = 11;
`else
  localparam int          FRAME_BITS = 10;
`endif
  localparam int          WAIT_MAX = 2 * FRAME_BITS * BIT_CLK;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  int         perr_cnt = 0;
`endif

  int          checks    = 0;
  int          failures  = 0;
  int          done_cnt  = 0;
  int          ferr_cnt  = 0;
  longint      cyc       = 0;
  logic [7:0]  exp_q[$];
  longint      done_cyc[$];
  logic [7:0]  exp_b;
  logic        prev_done = 1'b0;
  bit          par_flip  = 1'b0;

  uart_rx_deserializer #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .rx_busy  (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Scoreboard: every rx_done pops one expected byte
  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_unexpected: rx_done with rx_data=%h, none expected", rx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (rx_data !== exp_b) begin
          failures++;
          $display("FAIL scoreboard_data: rx_data=%h expected=%h", rx_data, exp_b);
        end
      end
      checks++;
      if (frame_err !== 1'b0) begin
        failures++;
        $display("FAIL done_with_frame_err: frame_err=%b expected=0", frame_err);
      end
      checks++;
      if (prev_done !== 1'b0) begin
        failures++;
        $display("FAIL done_pulse_width: previous rx_done=%b expected=0", prev_done);
      end
    end
    if (frame_err) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_cnt++;
`endif
    prev_done = rx_done;
  end

  // Drive one full frame, called aligned to a falling clock edge
  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    repeat (BIT_CLK) @(negedge clk);
`endif
    rx = stop_v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data: got=%h expected=00", rx_data); end
    checks++;
    if (rx_done !== 1'b0) begin failures++; $display("FAIL reset_rx_done: got=%b expected=0", rx_done); end
    checks++;
    if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got=%b expected=0", frame_err); end
    checks++;
    if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_rx_busy: got=%b expected=0", rx_busy); end
`ifdef UART_RX_PARITY_EN
    checks++;
    if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity_err: got=%b expected=0", parity_err); end
`endif
    reset = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic test_single();
    int d0 = done_cnt;
    int f0 = ferr_cnt;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    for (int i = 0; i < WAIT_MAX && done_cnt < d0 + 1; i++) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1) begin failures++; $display("FAIL single_done_count: got=%0d expected=%0d", done_cnt - d0, 1); end
    checks++;
    if (ferr_cnt !== f0) begin failures++; $display("FAIL single_frame_err: pulses=%0d expected=0", ferr_cnt - f0); end
    repeat (2) @(negedge clk);
    checks++;
    if (rx_busy !== 1'b0) begin failures++; $display("FAIL single_busy_after: got=%b expected=0", rx_busy); end
    checks++;
    if (rx_data !== 8'h55) begin failures++; $display("FAIL single_hold: rx_data=%h expected=55", rx_data); end
  endtask

  task automatic test_back_to_back();
    int     d0 = done_cnt;
    int     s0 = done_cyc.size();
    longint gap;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h30);
    send_frame(8'h5A, 1'b1);
    send_frame(8'h30, 1'b1);
    for (int i = 0; i < WAIT_MAX && done_cnt < d0 + 2; i++) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 2) begin
      failures++;
      $display("FAIL b2b_done_count: got=%0d expected=2", done_cnt - d0);
    end else begin
      gap = done_cyc[s0 + 1] - done_cyc[s0];
      checks++;
      if (gap < longint'(FRAME_BITS * BIT_CLK - 3) || gap > longint'(FRAME_BITS * BIT_CLK + 3)) begin
        failures++;
        $display("FAIL b2b_gap: got=%0d clk expected=%0d", gap, FRAME_BITS * BIT_CLK);
      end
    end
    checks++;
    if (rx_data !== 8'h30) begin failures++; $display("FAIL b2b_last: rx_data=%h expected=30", rx_data); end
  endtask

  task automatic test_glitch();
    int d0 = done_cnt;
    int f0 = ferr_cnt;
    rx = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (rx_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_during: got=%b expected=1", rx_busy); end
    rx = 1'b1;
    repeat (48) @(negedge clk);
    checks++;
    if (rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_after: got=%b expected=0", rx_busy); end
    repeat (2 * BIT_CLK) @(negedge clk);
    checks++;
    if (done_cnt !== d0 || ferr_cnt !== f0) begin
      failures++;
      $display("FAIL glitch_pulses: done=%0d ferr=%0d expected 0 and 0", done_cnt - d0, ferr_cnt - f0);
    end
  endtask

  task automatic test_frame_err();
    int d0 = done_cnt;
    int f0 = ferr_cnt;
    send_frame(8'h31, 1'b0);
    repeat (5 * BIT_CLK) @(negedge clk);
    checks++;
    if (ferr_cnt !== f0 + 1) begin failures++; $display("FAIL ferr_count: got=%0d expected=1", ferr_cnt - f0); end
    checks++;
    if (done_cnt !== d0) begin failures++; $display("FAIL ferr_no_done: got=%0d expected=0", done_cnt - d0); end
    checks++;
    if (rx_data !== 8'h30) begin failures++; $display("FAIL ferr_data_kept: rx_data=%h expected=30", rx_data); end
    checks++;
    if (rx_busy !== 1'b0) begin failures++; $display("FAIL ferr_stuck_low_busy: got=%b expected=0", rx_busy); end
    rx = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    exp_q.push_back(8'h32);
    send_frame(8'h32, 1'b1);
    for (int i = 0; i < WAIT_MAX && done_cnt < d0 + 1; i++) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1) begin failures++; $display("FAIL ferr_recover_count: got=%0d expected=1", done_cnt - d0); end
    checks++;
    if (rx_data !== 8'h32) begin failures++; $display("FAIL ferr_recover_data: rx_data=%h expected=32", rx_data); end
    checks++;
    if (ferr_cnt !== f0 + 1) begin failures++; $display("FAIL ferr_recover_ferr: got=%0d expected=1", ferr_cnt - f0); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d = 8'h44;
    int d0;
    int f0;
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx = d[4];
    repeat (BIT_CLK / 2) @(negedge clk);
    reset = 1'b0;
    rx    = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rx_data !== 8'h00) begin failures++; $display("FAIL midrst_rx_data: got=%h expected=00", rx_data); end
    checks++;
    if (rx_busy !== 1'b0) begin failures++; $display("FAIL midrst_rx_busy: got=%b expected=0", rx_busy); end
    checks++;
    if (rx_done !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL midrst_pulses: rx_done=%b frame_err=%b expected 0 and 0", rx_done, frame_err);
    end
    repeat (BIT_CLK) @(negedge clk);
    reset = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    d0 = done_cnt;
    f0 = ferr_cnt;
    exp_q.push_back(8'h64);
    send_frame(8'h64, 1'b1);
    for (int i = 0; i < WAIT_MAX && done_cnt < d0 + 1; i++) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1) begin failures++; $display("FAIL midrst_done_count: got=%0d expected=1", done_cnt - d0); end
    checks++;
    if (rx_data !== 8'h64) begin failures++; $display("FAIL midrst_data: rx_data=%h expected=64", rx_data); end
    checks++;
    if (ferr_cnt !== f0) begin failures++; $display("FAIL midrst_ferr: got=%0d expected=0", ferr_cnt - f0); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int d0 = done_cnt;
    int p0 = perr_cnt;
    par_flip = 1'b1;
    send_frame(8'h43, 1'b1);
    par_flip = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    checks++;
    if (perr_cnt !== p0 + 1) begin failures++; $display("FAIL parity_err_count: got=%0d expected=1", perr_cnt - p0); end
    checks++;
    if (done_cnt !== d0) begin failures++; $display("FAIL parity_no_done: got=%0d expected=0", done_cnt - d0); end
    checks++;
    if (rx_data !== 8'h64) begin failures++; $display("FAIL parity_data_kept: rx_data=%h expected=64", rx_data); end
    exp_q.push_back(8'h43);
    send_frame(8'h43, 1'b1);
    for (int i = 0; i < WAIT_MAX && done_cnt < d0 + 1; i++) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1) begin failures++; $display("FAIL parity_good_count: got=%0d expected=1", done_cnt - d0); end
    checks++;
    if (rx_data !== 8'h43) begin failures++; $display("FAIL parity_good_data: rx_data=%h expected=43", rx_data); end
    checks++;
    if (perr_cnt !== p0 + 1) begin failures++; $display("FAIL parity_good_perr: got=%0d expected=1", perr_cnt - p0); end
  endtask
`endif

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    repeat (BIT_CLK) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: %0d bytes never received, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- UART receiver front end: samples asynchronous serial line `rx`, recovers 8N1 frames and delivers `rx_data` with a one-cycle `rx_done` strobe.
- Sits directly upstream of the UART command decoder, which consumes `rx_data`/`rx_done` to generate button, door, reset and mode commands.
- Internal 16x oversampling tick generator; no external baud tick needed.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz
- BAUD, 9600, line bit rate
- OVERSAMPLE, 16, ticks per bit; must be even and ≥8
- DIV = CLK_HZ/(BAUD*OVERSAMPLE), rounded to nearest, derived localparam (651 at defaults); clog2-sized counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted); one clock domain only
- rx  in  1  serial line, idle high, asynchronous to clk
- rx_data  out  8  last correctly framed byte, LSB received first
- rx_done  out  1  one-clk pulse: rx_data updated this cycle
- frame_err  out  1  one-clk pulse: stop bit sampled low, byte discarded
- rx_busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Reset values: rx_data=8'h00, rx_done=0, frame_err=0, rx_busy=0, state=IDLE, sync FFs=1 (idle line), tick/bit counters=0.
- Input sync: 2-FF synchronizer on rx; one further FF holds previous synced value for edge detect. All decisions use the synced value.
- Tick gen: counter 0..DIV-1; `tick` pulse when count=DIV-1. Counter forced to 0 on IDLE→START so sampling phase aligns to the start edge.
- FSM:
  - IDLE: on synced falling edge (prev=1, now=0) → START; clear sample counter.
  - START: count OVERSAMPLE/2 ticks. Sample rx at that point. If 0 → DATA, clear counters. If 1 (glitch) → IDLE, with no pulse.
  - DATA: every OVERSAMPLE ticks sample rx and shift right into shift reg (new bit enters MSB). After 8th sample → STOP (or PARITY if feature enabled).
  - STOP: after OVERSAMPLE ticks sample rx. If 1: rx_data<=shift reg and rx_done=1 next cycle. If 0: frame_err=1, rx_data unchanged. Either way → IDLE.
- Latency: rx_done rises ≈9.5 bit times + 3 clk after the rx falling edge at the pin.
- Pulses are exactly one clk wide. rx_done and frame_err are never high together.
- Break/stuck-low line: IDLE requires a falling edge, so a line held low after a frame error produces no further frames until it returns high.
- Back-to-back frames: a start edge immediately after stop-bit mid-sample is accepted. IDLE is entered on the same cycle as the pulse.
- Reset mid-frame: all state and outputs return to reset values immediately; a partial byte is discarded.
- rx_data holds its value between frames; downstream samples it only on rx_done.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Frame becomes 8E1; state PARITY is inserted between DATA and STOP.
  - Received parity bit sampled after OVERSAMPLE ticks.
  - Port `parity_err` (out, 1) pulses in the STOP-completion cycle if XOR(data bits, parity bit) ≠ 0.
  - On parity error rx_done is suppressed and rx_data is unchanged; frame_err takes priority if both errors occur.
- Undefined: 8N1 only; no PARITY state and no parity_err port.

Test Plan (CLK_HZ=1_600_000, BAUD=10_000 → DIV=10, 160 clk/bit):
- Send 8'h55 ('U') 8N1 → one rx_done pulse, rx_data=8'h55, frame_err never high, rx_busy low after pulse.
- Send 'Z' (8'h5A) then '0' (8'h30) with zero idle gap → two rx_done pulses ≈1600 clk apart, rx_data 8'h5A then 8'h30.
- rx low for 40 clk, then high → START aborts to IDLE, no rx_done/frame_err, rx_busy low by clk ~85.
- Send 8'h31 with stop bit driven 0 → frame_err one pulse, rx_done 0, rx_data keeps previous value; line held low 5 bit times, then a valid 8'h32 → only 8'h32 received.
- Assert reset (0) at data bit 4 of 8'h44, release, send 8'h64 → outputs zero during reset, single rx_done with rx_data=8'h64.
- UART_RX_PARITY_EN: send 8'h43 with wrong parity → parity_err pulse, no rx_done. Correct parity → rx_done, rx_data=8'h43.
